// File: rtl/rename_dispatch_queue.sv
// rename_dispatch_queue: multi-lane elastic bundle queue between Rename and Dispatch
module rename_dispatch_queue #(
  parameter int WIDTH = 4,
  parameter int PKT_W = 128,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           laneActive_i,
  input  logic                       bundleValid_i,
  input  logic [WIDTH-1:0]           laneValid_i,
  input  logic [WIDTH*PKT_W-1:0]     data_i,
  output logic                       renameReady_o,
  input  logic                       stall_i,
  output logic                       bundleValid_o,
  output logic [WIDTH-1:0]           laneValid_o,
  output logic [WIDTH*PKT_W-1:0]     data_o,
  output logic [WIDTH-1:0]           valid_bundle_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  logic [PW-1:0]          head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]          count_q, count_d;
  logic [WIDTH-1:0]       lv_mem_q [DEPTH];
  logic [WIDTH*PKT_W-1:0] data_mem_q [DEPTH];
  logic                   kill, push, pop;
  logic [WIDTH-1:0]       lv_in;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH-1) ? '0 : p + 1'b1;
  endfunction
  // handshake, lane masking, output isolation and next pointer/count state
  always_comb begin
    kill           = reset | flush_i;
    lv_in          = laneValid_i & laneActive_i;
    renameReady_o  = (count_q != CW'(DEPTH)) & ~kill;
    push           = bundleValid_i & renameReady_o & (|lv_in);
    bundleValid_o  = (count_q != '0) & ~kill;
    laneValid_o    = lv_mem_q[head_q] & laneActive_i & {WIDTH{bundleValid_o}};
    pop            = bundleValid_o & ~stall_i;
    valid_bundle_o = laneValid_o & {WIDTH{~stall_i}};
    occupancy_o    = count_q;
    data_o         = '0;
    for (int i = 0; i < WIDTH; i++)
      data_o[i*PKT_W +: PKT_W] = laneValid_o[i] ? data_mem_q[head_q][i*PKT_W +: PKT_W] : '0;
    head_d  = kill ? '0 : pop ? nxt(head_q) : head_q;
    tail_d  = kill ? '0 : push ? nxt(tail_q) : tail_q;
    count_d = kill ? '0 : count_q + CW'(push) - CW'(pop);
  end
  // pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  // bundle storage, written only on a stored accept
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        lv_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
    end else if (push) begin
      lv_mem_q[tail_q]   <= lv_in;
      data_mem_q[tail_q] <= data_i;
    end
  end
endmodule

// File: tb/tb_rename_dispatch_queue.sv
// tb_rename_dispatch_queue: directed vector table plus DEPTH=3 random scoreboard sweep
module tb_rename_dispatch_queue;
  localparam int W = 4;
  localparam int P = 16;
  logic clk = 0;
  logic reset, flush;
  logic [W-1:0] act, lv;
  logic bv, st;
  logic [W*P-1:0] din;
  logic r2, b2, r3, b3;
  logic [W-1:0] l2, v2, l3, v3;
  logic [W*P-1:0] d2, d3;
  logic [1:0] o2, o3;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  rename_dispatch_queue #(.WIDTH(W), .PKT_W(P), .DEPTH(2)) u2 (
    .clk(clk), .reset(reset), .flush_i(flush), .laneActive_i(act), .bundleValid_i(bv),
    .laneValid_i(lv), .data_i(din), .renameReady_o(r2), .stall_i(st), .bundleValid_o(b2),
    .laneValid_o(l2), .data_o(d2), .valid_bundle_o(v2), .occupancy_o(o2));
  rename_dispatch_queue #(.WIDTH(W), .PKT_W(P), .DEPTH(3)) u3 (
    .clk(clk), .reset(reset), .flush_i(flush), .laneActive_i(act), .bundleValid_i(bv),
    .laneValid_i(lv), .data_i(din), .renameReady_o(r3), .stall_i(st), .bundleValid_o(b3),
    .laneValid_o(l3), .data_o(d3), .valid_bundle_o(v3), .occupancy_o(o3));
  typedef struct {
    logic rst, fl, bv, st, rdy, bvo;
    logic [W-1:0] act, lv, lvo, vbo;
    int tag, occ, otag;
  } vec_t;
  typedef struct {
    logic [W-1:0] lv;
    int tag;
  } ent_t;
  vec_t tbl[$];
  ent_t q[$];
  function automatic logic [W*P-1:0] dat(input int tag, input logic [W-1:0] m);
    logic [W*P-1:0] r = '0;
    for (int i = 0; i < W; i++)
      if (m[i]) r[i*P +: P] = {tag[11:0], i[3:0]};
    return r;
  endfunction
  task automatic chk(input string nm, input int row, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s row %0d got %h exp %h", nm, row, got, exp);
    end
  endtask
  task automatic add(input int rst, input int fl, input int a, input int b, input int l, input int s,
                     input int tag, input int rdy, input int bvo, input int lvo, input int vbo,
                     input int occ, input int otag);
    vec_t v;
    v.rst = rst[0]; v.fl = fl[0]; v.act = a[3:0]; v.bv = b[0]; v.lv = l[3:0]; v.st = s[0];
    v.tag = tag; v.rdy = rdy[0]; v.bvo = bvo[0]; v.lvo = lvo[3:0]; v.vbo = vbo[3:0];
    v.occ = occ; v.otag = otag;
    tbl.push_back(v);
  endtask
  initial begin
    reset = 1; flush = 0; act = 4'hF; bv = 0; lv = 0; st = 0; din = '0;
    repeat (2) @(posedge clk);
    //   rst fl act bv lv st tag | rdy bvo lvo vbo occ otag
    add(1, 0, 15, 1, 15, 0, 99,   0, 0, 0, 0, 0, 0);
    add(0, 0, 15, 0, 0, 0, 0,     1, 0, 0, 0, 0, 0);
    add(0, 0, 15, 1, 15, 0, 1,    1, 0, 0, 0, 0, 0);
    for (int t = 2; t <= 8; t++)
      add(0, 0, 15, 1, 15, 0, t,  1, 1, 15, 15, 1, t - 1);
    add(0, 0, 15, 0, 0, 0, 0,     1, 1, 15, 15, 1, 8);
    add(0, 0, 15, 1, 15, 1, 9,    1, 0, 0, 0, 0, 0);
    add(0, 0, 15, 1, 15, 1, 10,   1, 1, 15, 0, 1, 9);
    for (int t = 11; t <= 13; t++)
      add(0, 0, 15, 1, 15, 1, t,  0, 1, 15, 0, 2, 9);
    add(0, 0, 15, 1, 15, 0, 14,   0, 1, 15, 15, 2, 9);
    add(0, 0, 15, 1, 15, 0, 14,   1, 1, 15, 15, 1, 10);
    add(0, 0, 15, 0, 0, 0, 0,     1, 1, 15, 15, 1, 14);
    add(0, 0, 3, 1, 15, 1, 20,    1, 0, 0, 0, 0, 0);
    add(0, 0, 3, 1, 12, 1, 21,    1, 1, 3, 0, 1, 20);
    add(0, 0, 3, 0, 0, 1, 0,      1, 1, 3, 0, 1, 20);
    add(0, 0, 1, 0, 0, 0, 0,      1, 1, 1, 1, 1, 20);
    add(0, 0, 15, 0, 0, 0, 0,     1, 0, 0, 0, 0, 0);
    add(0, 0, 3, 1, 15, 1, 22,    1, 0, 0, 0, 0, 0);
    add(0, 0, 15, 0, 0, 0, 0,     1, 1, 3, 3, 1, 22);
    add(0, 0, 15, 1, 5, 0, 40,    1, 0, 0, 0, 0, 0);
    add(0, 0, 15, 1, 0, 0, 41,    1, 1, 5, 5, 1, 40);
    add(0, 0, 15, 0, 0, 0, 0,     1, 0, 0, 0, 0, 0);
    add(0, 0, 15, 1, 15, 1, 30,   1, 0, 0, 0, 0, 0);
    add(0, 0, 15, 1, 15, 1, 31,   1, 1, 15, 0, 1, 30);
    add(0, 1, 15, 1, 15, 0, 32,   0, 0, 0, 0, 2, 0);
    add(0, 0, 15, 1, 15, 0, 33,   1, 0, 0, 0, 0, 0);
    add(0, 0, 15, 0, 0, 0, 0,     1, 1, 15, 15, 1, 33);
    add(0, 0, 15, 0, 0, 0, 0,     1, 0, 0, 0, 0, 0);
    foreach (tbl[n]) begin
      @(negedge clk);
      reset = tbl[n].rst; flush = tbl[n].fl; act = tbl[n].act; bv = tbl[n].bv;
      lv = tbl[n].lv; st = tbl[n].st; din = dat(tbl[n].tag, 4'hF);
      #1;
      chk("ready", n, 64'(r2), 64'(tbl[n].rdy));
      chk("bundle_valid", n, 64'(b2), 64'(tbl[n].bvo));
      chk("lane_valid", n, 64'(l2), 64'(tbl[n].lvo));
      chk("valid_bundle", n, 64'(v2), 64'(tbl[n].vbo));
      chk("occupancy", n, 64'(o2), 64'(tbl[n].occ));
      chk("data", n, 64'(d2), 64'(dat(tbl[n].otag, tbl[n].lvo)));
    end
    @(negedge clk);
    reset = 1; flush = 0; bv = 0; st = 0; act = 4'hF;
    for (int c = 0; c < 1000; c++) begin
      logic rdy, bvo;
      logic [W-1:0] lvo, hlv;
      int htag;
      @(negedge clk);
      reset = 0;
      flush = $urandom_range(0, 39) == 0;
      bv = $urandom_range(0, 3) != 0;
      lv = W'($urandom);
      act = $urandom_range(0, 7) == 0 ? W'($urandom) : 4'hF;
      st = $urandom_range(0, 1) == 0;
      din = dat(c + 100, 4'hF);
      #1;
      hlv = q.size() != 0 ? q[0].lv : '0;
      htag = q.size() != 0 ? q[0].tag : 0;
      rdy = q.size() != 3 && !flush;
      bvo = q.size() != 0 && !flush;
      lvo = hlv & act & {W{bvo}};
      chk("s3_ready", c, 64'(r3), 64'(rdy));
      chk("s3_bundle_valid", c, 64'(b3), 64'(bvo));
      chk("s3_lane_valid", c, 64'(l3), 64'(lvo));
      chk("s3_valid_bundle", c, 64'(v3), 64'(lvo & {W{~st}}));
      chk("s3_occupancy", c, 64'(o3), 64'(q.size()));
      chk("s3_data", c, 64'(d3), 64'(dat(htag, lvo)));
      if (flush) q.delete();
      else begin
        if (bvo && !st) void'(q.pop_front());
        if (bv && rdy && (lv & act) != 0) q.push_back('{lv & act, c + 100});
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
